// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-side signals of dmem_arbiter.
// slave = arbiter view; master = requesters plus memory (bench/system view).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Port C (core load/store unit)
  logic              c_req_valid;
  logic              c_req_ready;
  logic              c_req_we;
  logic [BE_W-1:0]   c_req_be;
  logic [ADDR_W-1:0] c_req_addr;
  logic [DATA_W-1:0] c_req_wdata;
  logic              c_rsp_valid;
  logic [DATA_W-1:0] c_rsp_rdata;

  // Port D (debug / loader)
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [BE_W-1:0]   d_req_be;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_rdata;

  // Single-port data memory
  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req_valid, c_req_we, c_req_be, c_req_addr, c_req_wdata,
    output c_req_ready, c_rsp_valid, c_rsp_rdata,
    input  d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req_valid, c_req_we, c_req_be, c_req_addr, c_req_wdata,
    input  c_req_ready, c_rsp_valid, c_rsp_rdata,
    output d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between core (C, fixed priority) and debug (D, forced win after MAX_WAIT denials); DMEM_ARB_STATS_EN adds grant counters.
// Writes commit on the accept cycle, reads respond one cycle later; backpressure is a combinational req_ready, responses never stall accepts.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_c_grants,
  output logic [31:0]   stat_d_grants,
  output logic [31:0]   stat_d_forced
`endif
);
  localparam int         BE_W     = DATA_W / 8;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  req_t              c_req;
  req_t              d_req;
  req_t              win_req;
  owner_e            rsp_owner;
  owner_e            rsp_owner_nxt;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_cnt_nxt;
  logic              d_starved;
  logic              gnt_c;
  logic              gnt_d;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  assign c_req = {bus.c_req_we, bus.c_req_be, bus.c_req_addr, bus.c_req_wdata};
  assign d_req = {bus.d_req_we, bus.d_req_be, bus.d_req_addr, bus.d_req_wdata};

  // D overrides C only when both contend and D has already been denied MAX_WAIT times in a row.
  assign d_starved = bus.c_req_valid && bus.d_req_valid && (wait_cnt == WAIT_MAX);
  assign gnt_d     = rst_n && bus.d_req_valid && (!bus.c_req_valid || d_starved);
  assign gnt_c     = rst_n && bus.c_req_valid && !d_starved;

  assign bus.c_req_ready = gnt_c;
  assign bus.d_req_ready = gnt_d;

  always_comb begin
    win_req = '0;
    if (gnt_d) begin
      win_req = d_req;
    end else if (gnt_c) begin
      win_req = c_req;
    end
  end

  assign bus.mem_en    = gnt_c | gnt_d;
  assign bus.mem_we    = win_req.we;
  assign bus.mem_be    = win_req.be;
  assign bus.mem_addr  = win_req.addr;
  assign bus.mem_wdata = win_req.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner <= OWN_NONE;
      wait_cnt  <= '0;
    end else begin
      rsp_owner <= rsp_owner_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  always_comb begin
    rsp_owner_nxt = OWN_NONE;
    wait_cnt_nxt  = wait_cnt;
    if (gnt_c && !bus.c_req_we) begin
      rsp_owner_nxt = OWN_C;
    end else if (gnt_d && !bus.d_req_we) begin
      rsp_owner_nxt = OWN_D;
    end
    if (!bus.d_req_valid || gnt_d) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt_nxt = wait_cnt + 4'd1;
    end
  end

  // Each port's rdata keeps the last word delivered to it while the other port owns the response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (rsp_owner == OWN_C) c_rdata_q <= bus.mem_rdata;
      if (rsp_owner == OWN_D) d_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.c_rsp_valid = (rsp_owner == OWN_C);
  assign bus.d_rsp_valid = (rsp_owner == OWN_D);
  assign bus.c_rsp_rdata = (rsp_owner == OWN_C) ? bus.mem_rdata : c_rdata_q;
  assign bus.d_rsp_rdata = (rsp_owner == OWN_D) ? bus.mem_rdata : d_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_c_grants <= '0;
      stat_d_grants <= '0;
      stat_d_forced <= '0;
    end else begin
      if (gnt_c)              stat_c_grants <= stat_c_grants + 32'd1;
      if (gnt_d)              stat_d_grants <= stat_d_grants + 32'd1;
      if (gnt_d && d_starved) stat_d_forced <= stat_d_forced + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: read data expected per port is queued at accept and popped by the response monitor.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] exp_c[$];
  logic [31:0] exp_d[$];
  logic [31:0] ref_mem [0:63];
  logic [31:0] mem [0:63];
  logic [31:0] mem_rdata_q;
  logic [31:0] mon_c;
  logic [31:0] mon_d;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_c_grants;
  logic [31:0] stat_d_grants;
  logic [31:0] stat_d_forced;
`endif

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_c_grants (stat_c_grants),
    .stat_d_grants (stat_d_grants),
    .stat_d_forced (stat_d_forced)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h5A00_0000 + 32'(i * 4));
  endfunction

  // Behavioural single-port memory: read data valid the cycle after the strobe.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    mem_rdata_q = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en === 1'b1) begin
        if (bus.mem_we === 1'b1) begin
          for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end else begin
          mem_rdata_q <= mem[bus.mem_addr[7:2]];
        end
      end
    end
  end
  assign bus.mem_rdata = mem_rdata_q;

  // Response monitor: every rsp_valid must match the oldest outstanding read of that port.
  always @(negedge clk) begin
    if (bus.c_rsp_valid === 1'b1) begin
      n_vec++;
      if (exp_c.size() == 0) begin
        n_err++; $display("FAIL c_rsp_unexpected: got rdata %h, required no response", bus.c_rsp_rdata);
      end else begin
        mon_c = exp_c.pop_front();
        if (bus.c_rsp_rdata !== mon_c) begin
          n_err++; $display("FAIL c_rsp_data: got %h, required %h", bus.c_rsp_rdata, mon_c);
        end
      end
    end
    if (bus.d_rsp_valid === 1'b1) begin
      n_vec++;
      if (exp_d.size() == 0) begin
        n_err++; $display("FAIL d_rsp_unexpected: got rdata %h, required no response", bus.d_rsp_rdata);
      end else begin
        mon_d = exp_d.pop_front();
        if (bus.d_rsp_rdata !== mon_d) begin
          n_err++; $display("FAIL d_rsp_data: got %h, required %h", bus.d_rsp_rdata, mon_d);
        end
      end
    end
  end

  task automatic drive_c(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
    bus.c_req_valid = v; bus.c_req_we = we; bus.c_req_be = be;
    bus.c_req_addr = addr; bus.c_req_wdata = wd;
  endtask

  task automatic drive_d(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
    bus.d_req_valid = v; bus.d_req_we = we; bus.d_req_be = be;
    bus.d_req_addr = addr; bus.d_req_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_drain(input string name);
    next_cycle();
    drive_c(0, 0, 4'h0, 32'h0, 32'h0);
    drive_d(0, 0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_c.size() != 0 || exp_d.size() != 0) begin
      n_err++; $display("FAIL %s_drain: got %0d/%0d outstanding c/d reads, required 0/0", name, exp_c.size(), exp_d.size());
    end
  endtask

  task automatic test_reset();
    drive_c(1, 0, 4'hF, 32'h10, 32'h0);
    drive_d(1, 0, 4'hF, 32'h04, 32'h0);
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.c_req_ready !== 1'b0 || bus.d_req_ready !== 1'b0 || bus.mem_en !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got c_rdy=%b d_rdy=%b mem_en=%b, required 0 0 0", bus.c_req_ready, bus.d_req_ready, bus.mem_en);
    end
    n_vec++;
    if (bus.c_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp: got c_rsp=%b d_rsp=%b, required 0 0", bus.c_rsp_valid, bus.d_rsp_valid);
    end
    drive_c(0, 0, 4'h0, 32'h0, 32'h0);
    drive_d(0, 0, 4'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_core_load();
    next_cycle();
    drive_c(1, 0, 4'hF, 32'h0000_0010, 32'h0);
    @(negedge clk);
    n_vec++;
    if (bus.c_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0) begin
      n_err++; $display("FAIL core_load_ready: got c_rdy=%b d_rdy=%b, required 1 0", bus.c_req_ready, bus.d_req_ready);
    end
    n_vec++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h10) begin
      n_err++; $display("FAIL core_load_mem: got en=%b we=%b addr=%h, required 1 0 00000010", bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    exp_c.push_back(ref_mem[4]);
    next_cycle();
    drive_c(0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (bus.c_rsp_valid !== 1'b1 || bus.c_rsp_rdata !== 32'hDEADBEEF || bus.d_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL core_load_rsp: got c_rsp=%b rdata=%h d_rsp=%b, required 1 deadbeef 0", bus.c_rsp_valid, bus.c_rsp_rdata, bus.d_rsp_valid);
    end
    test_drain("core_load");
  endtask

  task automatic test_store_partial();
    next_cycle();
    drive_d(1, 1, 4'b0011, 32'h20, 32'h1234_5678);
    @(negedge clk);
    n_vec++;
    if (bus.d_req_ready !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0011 || bus.mem_wdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL store_d_mem: got rdy=%b we=%b be=%b wdata=%h, required 1 1 0011 12345678", bus.d_req_ready, bus.mem_we, bus.mem_be, bus.mem_wdata);
    end
    ref_mem[8][15:0] = 16'h5678;
    next_cycle();
    drive_d(0, 0, 4'h0, 32'h0, 32'h0);
    drive_c(1, 0, 4'hF, 32'h20, 32'h0);
    @(negedge clk);
    n_vec++;
    if (bus.c_req_ready !== 1'b1 || bus.d_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL store_then_load: got c_rdy=%b d_rsp=%b, required 1 0", bus.c_req_ready, bus.d_rsp_valid);
    end
    exp_c.push_back(ref_mem[8]);
    test_drain("store_partial");
  endtask

  task automatic test_alternating();
    bit          cv[4]     = '{1, 0, 1, 0};
    bit          dv[4]     = '{0, 1, 0, 0};
    logic [31:0] ad[4]     = '{32'h0, 32'h4, 32'h8, 32'h0};
    bit          exp_cr[4] = '{0, 1, 0, 1};
    bit          exp_dr[4] = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive_c(cv[i], 0, 4'hF, ad[i], 32'h0);
      drive_d(dv[i], 0, 4'hF, ad[i], 32'h0);
      @(negedge clk);
      n_vec++;
      if (bus.c_rsp_valid !== exp_cr[i] || bus.d_rsp_valid !== exp_dr[i]) begin
        n_err++; $display("FAIL alt_rsp[%0d]: got c_rsp=%b d_rsp=%b, required %b %b", i, bus.c_rsp_valid, bus.d_rsp_valid, exp_cr[i], exp_dr[i]);
      end
      n_vec++;
      if (bus.c_req_ready !== cv[i] || bus.d_req_ready !== dv[i]) begin
        n_err++; $display("FAIL alt_ready[%0d]: got c_rdy=%b d_rdy=%b, required %b %b", i, bus.c_req_ready, bus.d_req_ready, cv[i], dv[i]);
      end
      if (i == 2) begin
        n_vec++;
        if (bus.c_rsp_rdata !== ref_mem[0]) begin
          n_err++; $display("FAIL alt_c_hold: got %h, required %h", bus.c_rsp_rdata, ref_mem[0]);
        end
      end
      if (i == 3) begin
        n_vec++;
        if (bus.d_rsp_rdata !== ref_mem[1]) begin
          n_err++; $display("FAIL alt_d_hold: got %h, required %h", bus.d_rsp_rdata, ref_mem[1]);
        end
      end
      if (cv[i]) exp_c.push_back(ref_mem[ad[i][7:2]]);
      if (dv[i]) exp_d.push_back(ref_mem[ad[i][7:2]]);
    end
    test_drain("alternating");
  endtask

  task automatic test_contention();
    int c_idx = 0, d_idx = 0, d_wait = 0, max_wait = 0, c_acc = 0, d_acc = 0;
    bit d_win;
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      drive_c(1, 0, 4'hF, 32'(c_idx * 4), 32'h0);
      drive_d(1, 0, 4'hF, 32'h80 + 32'(d_idx * 4), 32'h0);
      @(negedge clk);
      d_win = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
      n_vec++;
      if (bus.c_req_ready !== !d_win || bus.d_req_ready !== d_win) begin
        n_err++; $display("FAIL contention_grant[%0d]: got c_rdy=%b d_rdy=%b, required %b %b", i, bus.c_req_ready, bus.d_req_ready, !d_win, d_win);
      end
      if (bus.c_req_ready === 1'b1) c_acc++;
      if (bus.d_req_ready === 1'b1) begin
        d_acc++; d_wait = 0;
      end else begin
        d_wait++;
      end
      if (d_wait > max_wait) max_wait = d_wait;
      if (d_win) begin
        exp_d.push_back(ref_mem[32 + d_idx]); d_idx++;
      end else begin
        exp_c.push_back(ref_mem[c_idx]); c_idx++;
      end
    end
    n_vec++;
    if (max_wait > MAX_WAIT) begin
      n_err++; $display("FAIL contention_max_wait: got %0d, required <= %0d", max_wait, MAX_WAIT);
    end
    n_vec++;
    if (c_acc != 12 || d_acc != 3) begin
      n_err++; $display("FAIL contention_accepts: got c=%0d d=%0d, required c=12 d=3", c_acc, d_acc);
    end
    test_drain("contention");
  endtask

  task automatic test_wait_clear();
    bit dv[8]    = '{1, 1, 0, 1, 1, 1, 1, 1};
    bit d_win[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      drive_c(1, 0, 4'hF, 32'h0, 32'h0);
      drive_d(dv[i], 0, 4'hF, 32'h84, 32'h0);
      @(negedge clk);
      n_vec++;
      if (bus.c_req_ready !== !d_win[i] || bus.d_req_ready !== d_win[i]) begin
        n_err++; $display("FAIL wait_clear_grant[%0d]: got c_rdy=%b d_rdy=%b, required %b %b", i, bus.c_req_ready, bus.d_req_ready, !d_win[i], d_win[i]);
      end
      if (d_win[i]) exp_d.push_back(ref_mem[33]);
      else          exp_c.push_back(ref_mem[0]);
    end
    test_drain("wait_clear");
  endtask

  task automatic test_reset_inflight();
    bit d_win;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive_c(1, 0, 4'hF, (i == 0) ? 32'h10 : 32'h0, 32'h0);
      drive_d(1, 0, 4'hF, 32'h84, 32'h0);
      @(negedge clk);
      n_vec++;
      if (bus.c_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0) begin
        n_err++; $display("FAIL inflight_pre[%0d]: got c_rdy=%b d_rdy=%b, required 1 0", i, bus.c_req_ready, bus.d_req_ready);
      end
      if (i == 0) exp_c.push_back(ref_mem[4]);
    end
    // Second read was accepted; reset lands before its response cycle.
    #1 rst_n = 1'b0;
    drive_c(0, 0, 4'h0, 32'h0, 32'h0);
    drive_d(0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (bus.c_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL inflight_in_reset: got c_rsp=%b d_rsp=%b, required 0 0", bus.c_rsp_valid, bus.d_rsp_valid);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.c_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL inflight_after_release: got c_rsp=%b d_rsp=%b, required 0 0", bus.c_rsp_valid, bus.d_rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive_c(1, 0, 4'hF, 32'h10, 32'h0);
      drive_d(1, 0, 4'hF, 32'h84, 32'h0);
      @(negedge clk);
      d_win = (i == 4);
      n_vec++;
      if (bus.c_req_ready !== !d_win || bus.d_req_ready !== d_win) begin
        n_err++; $display("FAIL inflight_post_grant[%0d]: got c_rdy=%b d_rdy=%b, required %b %b", i, bus.c_req_ready, bus.d_req_ready, !d_win, d_win);
      end
      if (d_win) exp_d.push_back(ref_mem[33]);
      else       exp_c.push_back(ref_mem[4]);
    end
    test_drain("reset_inflight");
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      drive_c(1, 0, 4'hF, 32'h0, 32'h0);
      drive_d(i >= 10, 0, 4'hF, 32'h84, 32'h0);
      if (i == 14) exp_d.push_back(ref_mem[33]);
      else         exp_c.push_back(ref_mem[0]);
    end
    test_drain("stats");
    n_vec++;
    if (stat_c_grants !== 32'd14 || stat_d_grants !== 32'd1 || stat_d_forced !== 32'd1) begin
      n_err++; $display("FAIL stats: got c=%0d d=%0d forced=%0d, required 14 1 1", stat_c_grants, stat_d_grants, stat_d_forced);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    drive_c(0, 0, 4'h0, 32'h0, 32'h0);
    drive_d(0, 0, 4'h0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    test_reset();
    test_core_load();
    test_store_partial();
    test_alternating();
    test_contention();
    test_wait_clear();
    test_reset_inflight();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got no completion by 100000 time units, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store unit (port C) and a debug/loader port (port D, used by the UART loader and bench back-door traffic).
- Per-port valid/ready request handshake; registered one-cycle read-response routing; fixed priority to the core with a bounded-starvation override for the debug port.
- Sits between Core/dbg logic and the dm instance.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; must be a multiple of 8; BE_W = DATA_W/8.
- MAX_WAIT, 4, consecutive cycles port D may be denied while requesting before it is forced to win; range 1..15.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- c_req_valid  in  1  core request valid.
- c_req_ready  out  1  core request accepted this cycle.
- c_req_we  in  1  1 = store, 0 = load.
- c_req_be  in  BE_W  store byte enables.
- c_req_addr  in  ADDR_W  byte address.
- c_req_wdata  in  DATA_W  store data.
- c_rsp_valid  out  1  load data valid for the core.
- c_rsp_rdata  out  DATA_W  load data.
- d_req_valid, d_req_ready, d_req_we, d_req_be, d_req_addr, d_req_wdata, d_rsp_valid, d_rsp_rdata: same as the c_ ports, for port D.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  BE_W  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wait_cnt = 0; rsp_owner = NONE.
  - c_rsp_valid = d_rsp_valid = 0.
  - Ready outputs are combinational and forced 0 while rst_n = 0.
  - An in-flight read is dropped: no rsp_valid after reset release.
- Arbitration is combinational each cycle; no bubble cycles:
  - Only one port valid: that port wins.
  - Both valid: C wins, unless wait_cnt == MAX_WAIT, in which case D wins.
  - Neither valid: mem_en = 0; mem_* data outputs are don't-care and driven 0.
- Winner: x_req_ready = 1 in the same cycle. mem_en = 1; mem_we, mem_be, mem_addr, mem_wdata are driven combinationally from the winner. The loser's ready = 0.
- A request is accepted when valid && ready. Requesters must hold their request fields stable until accepted.
- Write latency: 0. The accept cycle is the commit cycle; writes generate no response.
- Read latency: 1.
  - On read accept, rsp_owner <= winner.
  - Next cycle: x_rsp_valid = 1 for rsp_owner only; x_rsp_rdata = mem_rdata.
  - rsp_rdata for the non-owning port is held at its last value.
  - Back-to-back reads, including alternating ports, are supported at one per cycle.
- Starvation counter wait_cnt:
  - Increments when d_req_valid && !d_req_ready.
  - Clears on D accept, or when d_req_valid = 0.
  - Saturates at MAX_WAIT.
- Response phase and new request in the same cycle: both proceed. A response never blocks an accept.
- Both ports issuing the same address is allowed; ordering equals grant order.
- Core stall contract: the core must stall the pipeline while c_req_valid && !c_req_ready.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_c_grants [31:0], stat_d_grants [31:0], stat_d_forced [31:0].
  - The counters count accepts per port and MAX_WAIT-override grants.
  - They wrap at 2^32 and reset to 0 on rst_n.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Core-only load at 0x0000_0010 with mem containing 0xDEADBEEF -> c_req_ready = 1 in cycle 0; c_rsp_valid = 1 with rdata 0xDEADBEEF in cycle 1; d_rsp_valid stays 0.
- Both ports request continuously with MAX_WAIT = 4 -> grant pattern C,C,C,C,D repeating; D never waits more than 4 cycles; every request is eventually accepted.
- Store from D at 0x20 with be = 4'b0011, data 0x12345678, then core load of 0x20 -> returns {old[31:16], 16'h5678}.
- Alternating reads C@0x0, D@0x4, C@0x8 on consecutive cycles -> rsp_valid pulses on C, D, C in consecutive cycles with the matching data; no cross-delivery.
- Read accepted, then rst_n asserted before the response cycle -> no rsp_valid after release; wait_cnt = 0; first post-reset request is granted normally.
- With DMEM_ARB_STATS_EN, run 10 C-only then 5 contended cycles (MAX_WAIT = 4) -> stat_c_grants = 14, stat_d_grants = 1, stat_d_forced = 1.
